// File: rtl/modbus_crc16_if.sv
// modbus_crc16_if: groups the message, start request and CRC result of the
// CRC-16/MODBUS engine. The requester (RX or TX path) uses the master modport,
// the CRC engine uses the slave modport.
interface modbus_crc16_if #(
    parameter int BYTES = 6
);
    logic [BYTES*8-1:0] data_in;
    logic               rx_message_done;
    logic               crc_done;
    logic [15:0]        crc_out;

    modport master (
        output data_in,
        output rx_message_done,
        input  crc_done,
        input  crc_out
    );

    modport slave (
        input  data_in,
        input  rx_message_done,
        output crc_done,
        output crc_out
    );
endinterface

// File: rtl/modbus_crc16.sv
// modbus_crc16: CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF, no final
// XOR) over a BYTES-byte message captured on a start request. Bytes are
// consumed in order 0..BYTES-1, each LSB first.
// Build option: define MODBUS_CRC_BYTEWISE_EN to process a whole byte per clock
// instead of one bit per clock. Results are identical, only latency differs.
module modbus_crc16 #(
    parameter int BYTES = 6
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    modbus_crc16_if.slave bus
);

    localparam int MSG_W = BYTES * 8;
`ifdef MODBUS_CRC_BYTEWISE_EN
    localparam int STEPS = BYTES;
    localparam int SHIFT = 8;
`else
    localparam int STEPS = MSG_W;
    localparam int SHIFT = 1;
`endif
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [15:0] POLY     = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] step_cnt;
    logic [15:0]      crc_reg;
    logic [15:0]      crc_out_r;
    logic             crc_done_r;
    logic [MSG_W-1:0] msg_sr;
    logic             start_accept;

    // One reflected CRC bit-step: feedback is the outgoing LSB xor the data bit.
    function automatic logic [15:0] crc_bit_step(input logic [15:0] crc,
                                                 input logic        din);
        logic fb;
        fb = crc[0] ^ din;
        return (crc >> 1) ^ (fb ? POLY : 16'h0000);
    endfunction

`ifdef MODBUS_CRC_BYTEWISE_EN
    // Eight unrolled bit-steps, LSB of the byte first.
    function automatic logic [15:0] crc_byte_step(input logic [15:0] crc,
                                                  input logic [7:0]  din);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = crc_bit_step(c, din[i]);
        end
        return c;
    endfunction
`endif

    assign start_accept = (state == ST_IDLE) && bus.rx_message_done;

    // Message shift register: loaded on an accepted start, drained LSB-first while calculating.
    always_ff @(posedge clk_in) begin
        if (start_accept) begin
            msg_sr <= bus.data_in;
        end else if (state == ST_CALC) begin
            msg_sr <= msg_sr >> SHIFT;
        end
    end

    // Control FSM and CRC accumulator; result register only updates in DONE so partial values never leak.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            step_cnt   <= '0;
            crc_reg    <= CRC_INIT;
            crc_out_r  <= 16'h0000;
            crc_done_r <= 1'b0;
        end else begin
            crc_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.rx_message_done) begin
                        crc_reg  <= CRC_INIT;
                        step_cnt <= '0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
`ifdef MODBUS_CRC_BYTEWISE_EN
                    crc_reg <= crc_byte_step(crc_reg, msg_sr[7:0]);
`else
                    crc_reg <= crc_bit_step(crc_reg, msg_sr[0]);
`endif
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    crc_out_r  <= crc_reg;
                    crc_done_r <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.crc_out  = crc_out_r;
    assign bus.crc_done = crc_done_r;

endmodule

// File: tb/tb_modbus_crc16.sv
// tb_modbus_crc16: scoreboard bench for modbus_crc16 with BYTES=6 and BYTES=3
// instances. Expected CRCs are pushed when a start is driven and popped when
// crc_done is observed.
module tb_modbus_crc16;

`ifdef MODBUS_CRC_BYTEWISE_EN
    localparam int LAT6 = 6 + 1;
    localparam int LAT3 = 3 + 1;
`else
    localparam int LAT6 = 6 * 8 + 1;
    localparam int LAT3 = 3 * 8 + 1;
`endif
    localparam int RESTART_AT = (LAT6 > 12) ? 10 : 3;

    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    modbus_crc16_if #(.BYTES(6)) b6();
    modbus_crc16_if #(.BYTES(3)) b3();

    modbus_crc16 #(.BYTES(6)) dut6 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(b6.slave));
    modbus_crc16 #(.BYTES(3)) dut3 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(b3.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done6 = 0;
    int done3 = 0;
    int start6_edge = 0;
    int start3_edge = 0;
    logic [15:0] q6[$];
    logic [15:0] q3[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (b6.crc_done === 1'b1) done6++;
        if (b3.crc_done === 1'b1) done3++;
    end

    // Reference CRC-16/MODBUS, byte-at-a-time formulation.
    function automatic logic [15:0] crc_model(input logic [47:0] d, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, d[8*i +: 8]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 16'hA001;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic start6(input logic [47:0] d);
        @(posedge clk_in); #1;
        b6.data_in = d;
        b6.rx_message_done = 1'b1;
        start6_edge = cyc + 1;
        q6.push_back(crc_model(d, 6));
        @(posedge clk_in); #1;
        b6.rx_message_done = 1'b0;
    endtask

    task automatic start3(input logic [23:0] d, input int hold);
        @(posedge clk_in); #1;
        b3.data_in = d;
        b3.rx_message_done = 1'b1;
        start3_edge = cyc + 1;
        q3.push_back(crc_model({24'h0, d}, 3));
        repeat (hold) @(posedge clk_in);
        #1;
        b3.rx_message_done = 1'b0;
    endtask

    task automatic wait_done(input int sel, output logic [15:0] v, output int lat,
                             output bit to, output bit unstable);
        logic [15:0] prev;
        prev = (sel == 6) ? b6.crc_out : b3.crc_out;
        to = 1'b1; unstable = 1'b0; v = 16'h0000; lat = 0;
        for (int i = 0; i < LAT6 + 40; i++) begin
            @(negedge clk_in);
            if ((sel == 6) ? (b6.crc_done === 1'b1) : (b3.crc_done === 1'b1)) begin
                v   = (sel == 6) ? b6.crc_out : b3.crc_out;
                lat = cyc - ((sel == 6) ? start6_edge : start3_edge);
                to  = 1'b0;
                break;
            end
            if (((sel == 6) ? b6.crc_out : b3.crc_out) !== prev) unstable = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        b6.data_in = '0; b6.rx_message_done = 1'b0;
        b3.data_in = '0; b3.rx_message_done = 1'b0;
        repeat (3) @(negedge clk_in);
        total++; if (b6.crc_done !== 1'b0) begin bad++; $display("FAIL reset_done6 got=%b want=0", b6.crc_done); end
        total++; if (b6.crc_out !== 16'h0000) begin bad++; $display("FAIL reset_out6 got=%h want=0000", b6.crc_out); end
        total++; if (b3.crc_done !== 1'b0) begin bad++; $display("FAIL reset_done3 got=%b want=0", b3.crc_done); end
        total++; if (b3.crc_out !== 16'h0000) begin bad++; $display("FAIL reset_out3 got=%h want=0000", b3.crc_out); end
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        total++; if (done6 + done3 !== 0) begin bad++; $display("FAIL idle_no_done got=%0d want=0", done6 + done3); end
    endtask

    task automatic test_known_frames;
        logic [47:0] vec [2];
        logic [15:0] ref_crc [2];
        logic [15:0] v, e;
        int lat, d0;
        bit to, un;
        vec[0] = 48'h01_00_00_00_03_01; ref_crc[0] = 16'h0A84;
        vec[1] = 48'h03_00_01_00_06_01; ref_crc[1] = 16'h0B98;
        for (int k = 0; k < 2; k++) begin
            d0 = done6;
            start6(vec[k]);
            wait_done(6, v, lat, to, un);
            total++;
            if (to) begin
                bad++; $display("FAIL known%0d_timeout got=none want=done", k);
                q6.delete();
            end else begin
                e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
                total++; if (v !== e) begin bad++; $display("FAIL known%0d_sb got=%h want=%h", k, v, e); end
                total++; if (v !== ref_crc[k]) begin bad++; $display("FAIL known%0d_const got=%h want=%h", k, v, ref_crc[k]); end
                total++; if (lat !== LAT6) begin bad++; $display("FAIL known%0d_latency got=%0d want=%0d", k, lat, LAT6); end
                @(negedge clk_in);
                total++; if (b6.crc_done !== 1'b0) begin bad++; $display("FAIL known%0d_pulse_width got=%b want=0", k, b6.crc_done); end
                repeat (4) @(negedge clk_in);
                total++; if (done6 - d0 !== 1) begin bad++; $display("FAIL known%0d_done_count got=%0d want=1", k, done6 - d0); end
            end
        end
    endtask

    task automatic test_exception_hold;
        logic [15:0] v, e;
        int lat, d0;
        bit to, un;
        d0 = done3;
        start3(24'h02_83_01, 2);
        wait_done(3, v, lat, to, un);
        total++;
        if (to) begin
            bad++; $display("FAIL exc_timeout got=none want=done");
            q3.delete();
        end else begin
            e = (q3.size() > 0) ? q3.pop_front() : 16'hxxxx;
            total++; if (v !== e) begin bad++; $display("FAIL exc_sb got=%h want=%h", v, e); end
            total++; if (v !== 16'hF1C0) begin bad++; $display("FAIL exc_const got=%h want=F1C0", v); end
            total++; if (lat !== LAT3) begin bad++; $display("FAIL exc_latency got=%0d want=%0d", lat, LAT3); end
            repeat (LAT3 + 5) @(negedge clk_in);
            total++; if (done3 - d0 !== 1) begin bad++; $display("FAIL exc_done_count got=%0d want=1", done3 - d0); end
            total++; if (b3.crc_out !== 16'hF1C0) begin bad++; $display("FAIL exc_hold_out got=%h want=F1C0", b3.crc_out); end
        end
    endtask

    task automatic test_restart_ignored;
        logic [47:0] a, b;
        logic [15:0] v, e;
        int lat, d0;
        bit to, un;
        a = 48'h01_00_00_00_03_01;
        b = 48'h03_00_01_00_06_01;
        d0 = done6;
        start6(a);
        repeat (RESTART_AT - 2) @(posedge clk_in);
        #1;
        b6.data_in = b;
        b6.rx_message_done = 1'b1;
        @(posedge clk_in); #1;
        b6.rx_message_done = 1'b0;
        wait_done(6, v, lat, to, un);
        total++;
        if (to) begin
            bad++; $display("FAIL restart_timeout got=none want=done");
            q6.delete();
        end else begin
            e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
            total++; if (v !== e) begin bad++; $display("FAIL restart_first got=%h want=%h", v, e); end
            total++; if (lat !== LAT6) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", lat, LAT6); end
            repeat (LAT6 + 5) @(negedge clk_in);
            total++; if (done6 - d0 !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", done6 - d0); end
        end
        start6(b);
        wait_done(6, v, lat, to, un);
        total++;
        if (to) begin
            bad++; $display("FAIL restart_fresh_timeout got=none want=done");
            q6.delete();
        end else begin
            e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
            total++; if (v !== e) begin bad++; $display("FAIL restart_fresh got=%h want=%h", v, e); end
            total++; if (v !== 16'h0B98) begin bad++; $display("FAIL restart_fresh_const got=%h want=0B98", v); end
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] a, b;
        logic [15:0] v, e;
        int lat;
        bit to, un;
        a = {16'($urandom()), $urandom()};
        b = {16'($urandom()), $urandom()};
        @(posedge clk_in); #1;
        b6.data_in = a;
        b6.rx_message_done = 1'b1;
        start6_edge = cyc + 1;
        q6.push_back(crc_model(a, 6));
        wait_done(6, v, lat, to, un);
        total++;
        if (to) begin
            bad++; $display("FAIL b2b_first_timeout got=none want=done");
            b6.rx_message_done = 1'b0;
            q6.delete();
        end else begin
            e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
            total++; if (v !== e) begin bad++; $display("FAIL b2b_first got=%h want=%h", v, e); end
            // Still on the negedge of the crc_done cycle: next edge is in IDLE.
            b6.data_in = b;
            start6_edge = cyc + 1;
            q6.push_back(crc_model(b, 6));
            @(posedge clk_in); #1;
            b6.rx_message_done = 1'b0;
            wait_done(6, v, lat, to, un);
            total++;
            if (to) begin
                bad++; $display("FAIL b2b_second_timeout got=none want=done");
                q6.delete();
            end else begin
                e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
                total++; if (v !== e) begin bad++; $display("FAIL b2b_second got=%h want=%h", v, e); end
                total++; if (lat !== LAT6) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT6); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v, e;
        int lat, d0;
        bit to, un;
        start6(48'h01_00_00_00_03_01);
        repeat (LAT6 / 2) @(posedge clk_in);
        #3;
        d0 = done6;
        rst_n_in = 1'b0;
        #1;
        total++; if (b6.crc_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", b6.crc_done); end
        total++; if (b6.crc_out !== 16'h0000) begin bad++; $display("FAIL rstmid_out6 got=%h want=0000", b6.crc_out); end
        total++; if (b3.crc_out !== 16'h0000) begin bad++; $display("FAIL rstmid_out3 got=%h want=0000", b3.crc_out); end
        q6.delete();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (LAT6 + 10) @(negedge clk_in);
        total++; if (done6 !== d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=%0d", done6, d0); end
        start6(48'h03_00_01_00_06_01);
        wait_done(6, v, lat, to, un);
        total++;
        if (to) begin
            bad++; $display("FAIL rstmid_after_timeout got=none want=done");
            q6.delete();
        end else begin
            e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
            total++; if (v !== e) begin bad++; $display("FAIL rstmid_after got=%h want=%h", v, e); end
            total++; if (lat !== LAT6) begin bad++; $display("FAIL rstmid_latency got=%0d want=%0d", lat, LAT6); end
        end
    endtask

    task automatic test_random;
        logic [47:0] a;
        logic [15:0] v, e;
        int lat;
        bit to, un;
        for (int n = 0; n < 200; n++) begin
            a = {16'($urandom()), $urandom()};
            start6(a);
            wait_done(6, v, lat, to, un);
            total++;
            if (to) begin
                bad++; $display("FAIL rand6_%0d_timeout got=none want=done", n);
                q6.delete();
            end else begin
                e = (q6.size() > 0) ? q6.pop_front() : 16'hxxxx;
                total++; if (v !== e) begin bad++; $display("FAIL rand6_%0d got=%h want=%h data=%h", n, v, e, a); end
                total++; if (un) begin bad++; $display("FAIL rand6_%0d_stable got=changed want=held", n); end
                total++; if (lat !== LAT6) begin bad++; $display("FAIL rand6_%0d_latency got=%0d want=%0d", n, lat, LAT6); end
            end
        end
        for (int n = 0; n < 20; n++) begin
            start3(24'($urandom()), 1);
            wait_done(3, v, lat, to, un);
            total++;
            if (to) begin
                bad++; $display("FAIL rand3_%0d_timeout got=none want=done", n);
                q3.delete();
            end else begin
                e = (q3.size() > 0) ? q3.pop_front() : 16'hxxxx;
                total++; if (v !== e) begin bad++; $display("FAIL rand3_%0d got=%h want=%h", n, v, e); end
                total++; if (un) begin bad++; $display("FAIL rand3_%0d_stable got=changed want=held", n); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_known_frames;
        test_exception_hold;
        test_restart_ignored;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
